noise_replace_pipe: RTL

- Parametrised successor of the per-tap switching-stage replacement block.
- Takes one N_TAPS-pixel window, per-tap noise flags and the window median; outputs a cleaned window in which every flagged tap is replaced.
- Adds a valid/ready handshake, a 2-stage pipeline with backpressure, a second replacement mode, per-window noise count and all-noisy detection, and running statistics counters.
- Sits between the noise-detection/median stage and the output line writer.

---
 rtl/noise_rm_pkg.sv | 32 +++
 rtl/noise_replace_comb.sv | 52 +++++
 rtl/noise_replace_pipe.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/noise_rm_pkg.sv
// -----------------------------------------------------------------------------
// noise_rm_pkg
// Shared definitions for the noise replacement pipeline:
//   mode_e      - replacement mode encodings (median / previous clean tap)
//   MAX_TAPS    - largest supported window size
//   cnt_width() - bits needed to hold a count of 0..N
//   popcount()  - number of set bits in a flag vector (up to MAX_TAPS bits)
// -----------------------------------------------------------------------------
package noise_rm_pkg;

   typedef enum logic {
      MODE_MEDIAN     = 1'b0,
      MODE_PREV_CLEAN = 1'b1
   } mode_e;

   localparam int MAX_TAPS  = 25;
   localparam int MAX_CNT_W = 5;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_TAPS-1:0] f);
      logic [MAX_CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < MAX_TAPS; i++) begin
         c = c + {{(MAX_CNT_W-1){1'b0}}, f[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/noise_replace_comb.sv
// -----------------------------------------------------------------------------
// noise_replace_comb
// Combinational replacement datapath for one window.
//   i_x         - window pixels, tap i at [i*PIX_W +: PIX_W]
//   i_f         - per-tap noise flags (1 = noisy)
//   i_mv        - window median
//   i_mode      - MODE_MEDIAN or MODE_PREV_CLEAN
//   o_new_x     - cleaned window
//   o_noise_cnt - number of flagged taps
//   o_all_noisy - every tap flagged
// -----------------------------------------------------------------------------
module noise_replace_comb
   import noise_rm_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int N_TAPS = 9
) (
   input  logic [N_TAPS*PIX_W-1:0]        i_x,
   input  logic [N_TAPS-1:0]              i_f,
   input  logic [PIX_W-1:0]               i_mv,
   input  mode_e                          i_mode,
   output logic [N_TAPS*PIX_W-1:0]        o_new_x,
   output logic [cnt_width(N_TAPS)-1:0]   o_noise_cnt,
   output logic                           o_all_noisy
);

   localparam int NCW = cnt_width(N_TAPS);

   // Most recent clean tap seen while scanning upward; starts at the median so
   // a noisy run at the bottom of the window (or a fully noisy window) gets MV.
   logic [PIX_W-1:0] w_last;

   // Replacement mux chain, scanned from tap 0 upward.
   always_comb begin
      o_new_x = '0;
      w_last  = i_mv;
      for (int i = 0; i < N_TAPS; i++) begin
         if (i_f[i] == 1'b0) begin
            o_new_x[i*PIX_W +: PIX_W] = i_x[i*PIX_W +: PIX_W];
            w_last                    = i_x[i*PIX_W +: PIX_W];
         end else if (i_mode == MODE_PREV_CLEAN) begin
            o_new_x[i*PIX_W +: PIX_W] = w_last;
         end else begin
            o_new_x[i*PIX_W +: PIX_W] = i_mv;
         end
      end
   end

   assign o_noise_cnt = NCW'(popcount(MAX_TAPS'(i_f)));
   assign o_all_noisy = &i_f;

endmodule

// File: rtl/noise_replace_pipe.sv
// -----------------------------------------------------------------------------
// noise_replace_pipe
// Two-stage valid/ready pipeline replacing flagged taps of a pixel window.
//   Clk, Rst_n           - clock (rising edge), async active-low reset
//   In_Valid / In_Ready  - input handshake
//   X, F, MV, Mode       - window, noise flags, median, replacement mode
//   Out_Valid/Out_Ready  - output handshake
//   New_X                - cleaned window
//   Noise_Cnt, All_Noisy - flagged-tap count / all-flagged indication
//   Clr_Stats            - synchronous clear of the statistics counters
//   Win_Cnt              - delivered windows (wrapping)
//   Noisy_Acc            - replaced pixels (saturating)
// -----------------------------------------------------------------------------
module noise_replace_pipe
   import noise_rm_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int N_TAPS = 9,
   parameter int CNT_W  = 32
) (
   input  logic                           Clk,
   input  logic                           Rst_n,
   input  logic                           In_Valid,
   output logic                           In_Ready,
   input  logic [N_TAPS*PIX_W-1:0]        X,
   input  logic [N_TAPS-1:0]              F,
   input  logic [PIX_W-1:0]               MV,
   input  logic                           Mode,
   output logic                           Out_Valid,
   input  logic                           Out_Ready,
   output logic [N_TAPS*PIX_W-1:0]        New_X,
   output logic [cnt_width(N_TAPS)-1:0]   Noise_Cnt,
   output logic                           All_Noisy,
   input  logic                           Clr_Stats,
   output logic [CNT_W-1:0]               Win_Cnt,
   output logic [CNT_W-1:0]               Noisy_Acc
);

   localparam int NCW = cnt_width(N_TAPS);
   localparam int AW  = CNT_W + 1;

   // Stage 1 registers
   logic                      r_v1;
   logic [N_TAPS*PIX_W-1:0]   r_x1;
   logic [N_TAPS-1:0]         r_f1;
   logic [PIX_W-1:0]          r_mv1;
   mode_e                     r_mode1;

   // Stage 2 (output) registers
   logic                      r_v2;
   logic [N_TAPS*PIX_W-1:0]   r_new_x;
   logic [NCW-1:0]            r_noise_cnt;
   logic                      r_all_noisy;

   // Statistics
   logic [CNT_W-1:0]          r_win_cnt;
   logic [CNT_W-1:0]          r_noisy_acc;

   logic                      w_en1;
   logic                      w_en2;
   logic                      w_out_hs;
   logic [N_TAPS*PIX_W-1:0]   w_new_x;
   logic [NCW-1:0]            w_noise_cnt;
   logic                      w_all_noisy;
   logic [AW-1:0]             w_acc_sum;
   logic [CNT_W-1:0]          w_acc_next;

   // A stage advances when its successor is empty or draining this cycle.
   assign w_en2    = !r_v2 || Out_Ready;
   assign w_en1    = !r_v1 || w_en2;
   assign In_Ready = w_en1;
   assign w_out_hs = r_v2 && Out_Ready;

   // Carry out of the widened sum means the accumulator would overflow.
   assign w_acc_sum  = {1'b0, r_noisy_acc} + AW'(r_noise_cnt);
   assign w_acc_next = w_acc_sum[CNT_W] ? {CNT_W{1'b1}} : w_acc_sum[CNT_W-1:0];

   noise_replace_comb #(
      .PIX_W  (PIX_W),
      .N_TAPS (N_TAPS)
   ) u_comb (
      .i_x         (r_x1),
      .i_f         (r_f1),
      .i_mv        (r_mv1),
      .i_mode      (r_mode1),
      .o_new_x     (w_new_x),
      .o_noise_cnt (w_noise_cnt),
      .o_all_noisy (w_all_noisy)
   );

   // Stage 1: capture the window on input handshake.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_v1    <= 1'b0;
         r_x1    <= '0;
         r_f1    <= '0;
         r_mv1   <= '0;
         r_mode1 <= MODE_MEDIAN;
      end else if (w_en1) begin
         r_v1 <= In_Valid;
         if (In_Valid) begin
            r_x1    <= X;
            r_f1    <= F;
            r_mv1   <= MV;
            r_mode1 <= mode_e'(Mode);
         end
      end
   end

   // Stage 2: register the cleaned window; holds while stalled downstream.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_v2        <= 1'b0;
         r_new_x     <= '0;
         r_noise_cnt <= '0;
         r_all_noisy <= 1'b0;
      end else if (w_en2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_new_x     <= w_new_x;
            r_noise_cnt <= w_noise_cnt;
            r_all_noisy <= w_all_noisy;
         end
      end
   end

   // Statistics counters; clear takes priority over a same-cycle update.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_win_cnt   <= '0;
         r_noisy_acc <= '0;
      end else if (Clr_Stats) begin
         r_win_cnt   <= '0;
         r_noisy_acc <= '0;
      end else if (w_out_hs) begin
         r_win_cnt   <= r_win_cnt + CNT_W'(1);
         r_noisy_acc <= w_acc_next;
      end
   end

   assign Out_Valid = r_v2;
   assign New_X     = r_new_x;
   assign Noise_Cnt = r_noise_cnt;
   assign All_Noisy = r_all_noisy;
   assign Win_Cnt   = r_win_cnt;
   assign Noisy_Acc = r_noisy_acc;

endmodule
